// File: rtl/padd_pkg.sv
// Shared constants and types for pipelined_adder.
// Optional signed-overflow output is enabled by defining PADD_SIGNED_OVF_EN.
package padd_pkg;

  localparam int PADD_WIDTH_DEF  = 32;
  localparam int PADD_STAGES_DEF = 4;

  function automatic int padd_chunk(input int width, input int stages);
    return width / stages;
  endfunction

  // Default-width stage record; the top redefines it at its own WIDTH.
  typedef struct packed {
    logic                      valid;
    logic                      carry;
    logic [PADD_WIDTH_DEF-1:0] a_hi;
    logic [PADD_WIDTH_DEF-1:0] b_hi;
    logic [PADD_WIDTH_DEF-1:0] sum_lo;
  } padd_stage_def_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result stream bundle for pipelined_adder.
// The ovf signal exists only when PADD_SIGNED_OVF_EN is defined.
interface pipelined_adder_if #(
  parameter int WIDTH = padd_pkg::PADD_WIDTH_DEF
);
  // Handshake: a beat moves on a rising edge where valid && ready. A source
  // holds valid and data stable until accepted; ready may depend on valid.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PADD_SIGNED_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/padd_stage.sv
// One CHUNK-bit slice of the pipelined add plus its enabled pipeline register.
module padd_stage #(
  parameter int  CHUNK   = 8,
  parameter int  K       = 0,
  parameter type stage_t = padd_pkg::padd_stage_def_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  stage_t d,
  output stage_t q
);

  localparam int LO = K * CHUNK;

  logic [CHUNK:0] chunk_sum;
  stage_t         nxt;

  always_comb begin
    chunk_sum = {1'b0, d.a_hi[LO +: CHUNK]} + {1'b0, d.b_hi[LO +: CHUNK]}
              + (CHUNK+1)'(d.carry);
    nxt                    = d;
    nxt.sum_lo[LO +: CHUNK] = chunk_sum[CHUNK-1:0];
    nxt.carry              = chunk_sum[CHUNK];
  end

  // Data only loads with a real beat so the output holds across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      if (d.valid) q <= nxt;
      else         q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit a + b + cin split into STAGES carry-chained chunks, one per clock,
// with valid/ready streaming and full backpressure. Macro: PADD_SIGNED_OVF_EN.
module pipelined_adder
  import padd_pkg::*;
#(
  parameter int WIDTH  = PADD_WIDTH_DEF,
  parameter int STAGES = PADD_STAGES_DEF
) (
  input logic               clk,
  input logic               rst,
  pipelined_adder_if.slave  bus
);

  localparam int CHUNK = padd_chunk(WIDTH, STAGES);

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic [WIDTH-1:0] sum_lo;
  } stage_t;

  generate
    if ((STAGES < 1) || (STAGES > WIDTH) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end
  endgenerate

  stage_t head;
  stage_t pipe [STAGES];
  stage_t last;
  logic   en;
  logic   unused_ops;

  always_comb begin
    head        = '0;
    head.valid  = bus.in_valid;
    head.carry  = bus.cin;
    head.a_hi   = bus.a;
    head.b_hi   = bus.b;
  end

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
        padd_stage #(.CHUNK(CHUNK), .K(k), .stage_t(stage_t)) u_stage (
          .clk(clk), .rst(rst), .en(en), .d(head), .q(pipe[k])
        );
      end else begin : g_next
        padd_stage #(.CHUNK(CHUNK), .K(k), .stage_t(stage_t)) u_stage (
          .clk(clk), .rst(rst), .en(en), .d(pipe[k-1]), .q(pipe[k])
        );
      end
    end
  endgenerate

  // Whole pipe stalls only when the final beat is blocked downstream.
  assign last          = pipe[STAGES-1];
  assign en            = !last.valid || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = last.valid;
  assign bus.sum       = last.sum_lo;
  assign bus.cout      = last.carry;
  assign unused_ops    = ^{last.a_hi, last.b_hi};

`ifdef PADD_SIGNED_OVF_EN
  assign bus.ovf = (last.a_hi[WIDTH-1] == last.b_hi[WIDTH-1]) &&
                   (last.sum_lo[WIDTH-1] != last.a_hi[WIDTH-1]);
`endif

endmodule
